// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//
// Parametrised Moore serial pattern detector. One bit of `in` is consumed on
// every clock edge where en=1. The state is the length k (0..PAT_W) of the
// longest pattern prefix that is a suffix of the bits seen so far. `out` is
// high while k == PAT_W. Mismatches fall back KMP-style, so a valid partial
// prefix is kept. The pattern is run-time loadable through pat_load.
//
// Optional feature macro: SEQDET_CNT_EN
//   defined   -> saturating match counter (match_cnt, cnt_sat) is built
//   undefined -> match_cnt and cnt_sat are tied to 0, no counter flops
//
// Parameters
//   PAT_W    pattern length, 2..16
//   PATTERN  pattern loaded by reset, MSB = oldest bit
//   OVERLAP  1: overlapping matches, 0: history discarded after a match
//   CNT_W    match counter width, 2..32
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   en         sample strobe for `in`
//   in         serial data bit
//   pat_load   load pat_in as the new pattern (restarts detection and count)
//   pat_in     new pattern, MSB = oldest bit
//   out        registered match flag
//   match_cnt  matches since reset or pattern load (saturating)
//   cnt_sat    match_cnt has reached all-ones
// -----------------------------------------------------------------------------
module seq_detector #(
  parameter int              PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int KW = $clog2(PAT_W + 1);
  localparam logic [KW-1:0] IDLE  = '0;
  localparam logic [KW-1:0] MATCH = KW'(PAT_W);

  logic [KW-1:0]    state_reg, state_next;
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic             out_reg, out_next;

  // Pattern re-indexed so that bit t is the t-th oldest pattern bit, with one
  // spare zero bit on top so the history vector below can be PAT_W+1 wide.
  logic [PAT_W:0]   pat_fwd_ext;
  // Matched prefix followed by the incoming bit, oldest bit at index 0.
  logic [PAT_W:0]   hist;
  logic [KW-1:0]    k_from;
  logic [KW-1:0]    kmp_next;
  logic [PAT_W:0]   aligned;
  logic [PAT_W:0]   mask;

  genvar gi;

  assign pat_fwd_ext[PAT_W] = 1'b0;
  for (gi = 0; gi < PAT_W; gi++) begin : g_fwd
    assign pat_fwd_ext[gi] = pat_reg[PAT_W-1-gi];
  end

  // Without overlap, leaving MATCH behaves exactly like leaving IDLE.
  assign k_from = (state_reg == MATCH && !OVERLAP) ? IDLE : state_reg;

  // hist holds k_from pattern bits followed by `in`; bits above are zero.
  for (gi = 0; gi <= PAT_W; gi++) begin : g_hist
    assign hist[gi] = (k_from > KW'(gi)) ? pat_fwd_ext[gi]
                                         : ((k_from == KW'(gi)) & in);
  end

  // KMP fallback: try every candidate length j and keep the largest one whose
  // length-j suffix of hist equals the length-j pattern prefix. Shifting hist
  // right by (k_from+1-j) brings that suffix down to bit 0.
  always_comb begin
    kmp_next = IDLE;
    aligned  = '0;
    mask     = '0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= int'(k_from) + 1) begin
        aligned = hist >> (int'(k_from) + 1 - j);
        mask    = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - j);
        if (((aligned ^ pat_fwd_ext) & mask) == '0) begin
          kmp_next = KW'(j);
        end
      end
    end
  end

  // Next-state selection: pat_load beats en; en=0 holds everything.
  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    out_next   = out_reg;
    if (pat_load) begin
      pat_next   = pat_in;
      state_next = IDLE;
      out_next   = 1'b0;
    end else if (en) begin
      state_next = kmp_next;
      out_next   = (kmp_next == MATCH);
    end
  end

  // out_reg always equals (state_reg == MATCH); it is kept as its own flop so
  // the flag is glitch-free rather than a decode of the state bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      pat_reg   <= PATTERN;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      out_reg   <= out_next;
    end
  end

  assign out = out_reg;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_inc;

  // Every enabled sample that lands in MATCH counts, which covers both a
  // fresh entry and staying in MATCH on an all-equal overlapping pattern.
  assign cnt_inc = !pat_load && en && (kmp_next == MATCH);

  always_comb begin
    cnt_next = cnt_reg;
    if (pat_load) begin
      cnt_next = '0;
    end else if (cnt_inc && !(&cnt_reg)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign match_cnt = cnt_reg;
  assign cnt_sat   = &cnt_reg;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_detector
//
// Directed bench for seq_detector. Four instances share the serial inputs:
//   dut_a  defaults (PAT_W=3, 101, OVERLAP=1, CNT_W=8)
//   dut_b  OVERLAP=0
//   dut_c  PAT_W=4, reset pattern 0110
//   dut_d  CNT_W=2
// Expected counter values depend on whether SEQDET_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_detector;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       en       = 1'b0;
  logic       in       = 1'b0;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in3  = 3'b101;
  logic [3:0] pat_in4  = 4'b0110;

  logic       out_a, out_b, out_c, out_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;
  logic       sat_a, sat_b, sat_c, sat_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in), .pat_load(pat_load),
    .pat_in(pat_in3), .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detector #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in), .pat_load(pat_load),
    .pat_in(pat_in3), .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  seq_detector #(.PAT_W(4), .PATTERN(4'b0110)) dut_c (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in), .pat_load(pat_load),
    .pat_in(pat_in4), .out(out_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
  );

  seq_detector #(.CNT_W(2)) dut_d (
    .clk(clk), .reset_n(reset_n), .en(en), .in(in), .pat_load(pat_load),
    .pat_in(pat_in3), .out(out_d), .match_cnt(cnt_d), .cnt_sat(sat_d)
  );

  // Expected counter value after n matches on a w-bit counter.
  function automatic logic [31:0] exp_cnt(input int n, input int w);
`ifdef SEQDET_CNT_EN
    int top;
    top = (1 << w) - 1;
    return (n > top) ? 32'(top) : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic exp_sat(input int n, input int w);
`ifdef SEQDET_CNT_EN
    return (n >= (1 << w) - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic sample(input logic b);
    en = 1'b1;
    in = b;
    @(posedge clk);
    #1;
    en = 1'b0;
    in = 1'b0;
    $display("sample in=%b out a=%b b=%b c=%b d=%b cnt a=%0d b=%0d c=%0d d=%0d",
             b, out_a, out_b, out_c, out_d, cnt_a, cnt_b, cnt_c, cnt_d);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    in      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("reset applied for 2 edges");
    checks++;
    if (out_a !== 1'b0 || out_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got a=%b c=%b expected 0", out_a, out_c);
    end
    checks++;
    if (cnt_a !== 8'd0 || cnt_d !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt: got a=%0d d=%0d expected 0", cnt_a, cnt_d);
    end
    checks++;
    if (sat_a !== 1'b0 || sat_d !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: got a=%b d=%b expected 0", sat_a, sat_d);
    end
    en      = 1'b0;
    in      = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic stim  [7] = '{1, 0, 1, 1, 0, 1, 0};
    logic exp_o [7] = '{0, 0, 1, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sample(stim[i]);
      checks++;
      if (out_a !== exp_o[i] || out_b !== exp_o[i]) begin
        errors++;
        $display("FAIL basic_out sample %0d: got a=%b b=%b expected %b",
                 i + 1, out_a, out_b, exp_o[i]);
      end
    end
    checks++;
    if (32'(cnt_a) !== exp_cnt(2, 8) || 32'(cnt_b) !== exp_cnt(2, 8)) begin
      errors++;
      $display("FAIL basic_cnt: got a=%0d b=%0d expected %0d",
               cnt_a, cnt_b, exp_cnt(2, 8));
    end
  endtask

  task automatic test_overlap();
    logic stim  [5] = '{1, 0, 1, 0, 1};
    logic exp_a [5] = '{0, 0, 1, 0, 1};
    logic exp_b [5] = '{0, 0, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample(stim[i]);
      checks++;
      if (out_a !== exp_a[i]) begin
        errors++;
        $display("FAIL overlap_out_a sample %0d: got %b expected %b",
                 i + 1, out_a, exp_a[i]);
      end
      checks++;
      if (out_b !== exp_b[i]) begin
        errors++;
        $display("FAIL nonoverlap_out_b sample %0d: got %b expected %b",
                 i + 1, out_b, exp_b[i]);
      end
    end
    checks++;
    if (32'(cnt_a) !== exp_cnt(2, 8)) begin
      errors++;
      $display("FAIL overlap_cnt_a: got %0d expected %0d", cnt_a, exp_cnt(2, 8));
    end
    checks++;
    if (32'(cnt_b) !== exp_cnt(1, 8)) begin
      errors++;
      $display("FAIL nonoverlap_cnt_b: got %0d expected %0d", cnt_b, exp_cnt(1, 8));
    end
  endtask

  task automatic test_gating();
    do_reset();
    sample(1'b1);
    sample(1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      $display("gated cycle %0d in=%b out_a=%b", i, in, out_a);
      checks++;
      if (out_a !== 1'b0) begin
        errors++;
        $display("FAIL gating_idle cycle %0d: got %b expected 0", i, out_a);
      end
    end
    sample(1'b1);
    checks++;
    if (out_a !== 1'b1 || out_b !== 1'b1) begin
      errors++;
      $display("FAIL gating_match: got a=%b b=%b expected 1", out_a, out_b);
    end
    // out must hold while en stays low, whatever `in` does.
    for (int i = 0; i < 3; i++) begin
      in = i[0];
      @(posedge clk);
      #1;
      $display("hold cycle %0d out_a=%b", i, out_a);
      checks++;
      if (out_a !== 1'b1) begin
        errors++;
        $display("FAIL gating_hold cycle %0d: got %b expected 1", i, out_a);
      end
    end
    checks++;
    if (32'(cnt_a) !== exp_cnt(1, 8)) begin
      errors++;
      $display("FAIL gating_cnt: got %0d expected %0d", cnt_a, exp_cnt(1, 8));
    end
  endtask

  task automatic test_pat_load();
    logic pre   [6] = '{0, 1, 1, 0, 1, 1};
    logic exp_p [6] = '{0, 0, 0, 1, 0, 0};
    logic stim  [5] = '{1, 1, 1, 0, 1};
    logic exp_o [5] = '{0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sample(pre[i]);
      checks++;
      if (out_c !== exp_p[i]) begin
        errors++;
        $display("FAIL load_pre_out sample %0d: got %b expected %b",
                 i + 1, out_c, exp_p[i]);
      end
    end
    checks++;
    if (32'(cnt_c) !== exp_cnt(1, 8)) begin
      errors++;
      $display("FAIL load_pre_cnt: got %0d expected %0d", cnt_c, exp_cnt(1, 8));
    end
    // k=3 of 0110 here; a 0 would complete it, but the load must win.
    pat_in4  = 4'b1101;
    pat_load = 1'b1;
    en       = 1'b1;
    in       = 1'b0;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    en       = 1'b0;
    $display("pat_load 1101 with en=1 in=0 out_c=%b cnt_c=%0d", out_c, cnt_c);
    checks++;
    if (out_c !== 1'b0 || cnt_c !== 8'd0) begin
      errors++;
      $display("FAIL load_wins: got out=%b cnt=%0d expected out=0 cnt=0",
               out_c, cnt_c);
    end
    for (int i = 0; i < 5; i++) begin
      sample(stim[i]);
      checks++;
      if (out_c !== exp_o[i]) begin
        errors++;
        $display("FAIL load_kmp_out sample %0d: got %b expected %b",
                 i + 1, out_c, exp_o[i]);
      end
    end
    checks++;
    if (32'(cnt_c) !== exp_cnt(1, 8)) begin
      errors++;
      $display("FAIL load_kmp_cnt: got %0d expected %0d", cnt_c, exp_cnt(1, 8));
    end
  endtask

  task automatic test_back_to_back();
    logic exp_o [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic stim  [7] = '{1, 1, 1, 1, 1, 1, 0};
    pat_in4  = 4'b1111;
    pat_load = 1'b1;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    $display("pat_load 1111");
    for (int i = 0; i < 7; i++) begin
      sample(stim[i]);
      checks++;
      if (out_c !== exp_o[i]) begin
        errors++;
        $display("FAIL b2b_out sample %0d: got %b expected %b",
                 i + 1, out_c, exp_o[i]);
      end
    end
    checks++;
    if (32'(cnt_c) !== exp_cnt(3, 8)) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d expected %0d", cnt_c, exp_cnt(3, 8));
    end
  endtask

  task automatic test_reset_mid();
    logic stim  [5] = '{1, 0, 1, 1, 0};
    logic exp_a [5] = '{0, 0, 1, 0, 0};
    logic exp_c [5] = '{0, 0, 0, 0, 1};
    do_reset();
    sample(1'b1);
    sample(1'b0);
    reset_n = 1'b0;
    en      = 1'b1;
    in      = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    en      = 1'b0;
    $display("mid-pattern reset out_a=%b cnt_a=%0d", out_a, cnt_a);
    checks++;
    if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL midreset_state: got out=%b cnt=%0d expected 0 0", out_a, cnt_a);
    end
    // dut_c held 1111 before the reset; matching 0110 here proves the
    // reset pattern was restored.
    for (int i = 0; i < 5; i++) begin
      sample(stim[i]);
      checks++;
      if (out_a !== exp_a[i]) begin
        errors++;
        $display("FAIL midreset_out_a sample %0d: got %b expected %b",
                 i + 1, out_a, exp_a[i]);
      end
      checks++;
      if (out_c !== exp_c[i]) begin
        errors++;
        $display("FAIL midreset_out_c sample %0d: got %b expected %b",
                 i + 1, out_c, exp_c[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int pulses_a;
    int pulses_d;
    pulses_a = 0;
    pulses_d = 0;
    do_reset();
    sample(1'b1);
    for (int i = 0; i < 5; i++) begin
      sample(1'b0);
      sample(1'b1);
      if (out_a === 1'b1) pulses_a++;
      if (out_d === 1'b1) pulses_d++;
    end
    checks++;
    if (pulses_a != 5 || pulses_d != 5) begin
      errors++;
      $display("FAIL sat_pulses: got a=%0d d=%0d expected 5", pulses_a, pulses_d);
    end
    checks++;
    if (32'(cnt_d) !== exp_cnt(5, 2) || sat_d !== exp_sat(5, 2)) begin
      errors++;
      $display("FAIL sat_cnt_d: got cnt=%0d sat=%b expected cnt=%0d sat=%b",
               cnt_d, sat_d, exp_cnt(5, 2), exp_sat(5, 2));
    end
    checks++;
    if (32'(cnt_a) !== exp_cnt(5, 8) || sat_a !== exp_sat(5, 8)) begin
      errors++;
      $display("FAIL sat_cnt_a: got cnt=%0d sat=%b expected cnt=%0d sat=%b",
               cnt_a, sat_a, exp_cnt(5, 8), exp_sat(5, 8));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_gating();
    test_pat_load();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised Moore-style serial pattern detector: the successor to the fixed "101" Moore FSM. It samples one serial bit per enabled clock and asserts `out` while the most recent PAT_W sampled bits equal a run-time-loadable pattern. It supports overlapping or non-overlapping detection and an optional saturating match counter. It sits on a serial input line in front of framing/control logic that needs a registered, glitch-free match flag.

## Interface

- PAT_W, 3: pattern length in bits; legal range 2..16.
- PATTERN, 3'b101: pattern loaded at reset, MSB = oldest bit.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history cleared after each match.
- CNT_W, 8: match counter width; legal range 2..32.

- clk  input  1: rising-edge clock, single clock domain.
- reset_n  input  1: synchronous, active-low reset.
- en  input  1: sample strobe; `in` is consumed only on edges with en=1.
- in  input  1: serial data bit.
- pat_load  input  1: load `pat_in` into the pattern register.
- pat_in  input  PAT_W: new pattern, MSB = oldest bit.
- out  output  1: registered match flag (Moore, decoded from state only).
- match_cnt  output  CNT_W: number of matches since reset or pattern load.
- cnt_sat  output  1: match_cnt has reached all-ones.

## Operation

- State is the matched-prefix length k, 0..PAT_W. IDLE is k=0 and MATCH is k=PAT_W. `out` = (state==MATCH).
- On an enabled sample of bit b, the next state is the longest proper-or-full prefix of the pattern that is a suffix of (current matched prefix followed by b). This is KMP fallback: mismatches must not discard a valid partial prefix. Example: pattern 101, stream 1,1 leaves k=1.
- Leaving MATCH:
  - OVERLAP=1: fallback is computed from the full pattern plus b.
  - OVERLAP=0: the next state is computed as if leaving IDLE (history discarded).
- Each entry into MATCH increments match_cnt by 1. Staying in MATCH is impossible for PAT_W≥2 unless the pattern is all-equal with OVERLAP=1; in that case every enabled sample that keeps the state in MATCH also counts.
- match_cnt saturates at 2^CNT_W−1. cnt_sat=1 from then on; further matches do not wrap.
- Priority per edge: reset_n=0 > pat_load=1 > en=1 > hold.
- reset_n=0: pattern←PATTERN, state←IDLE, match_cnt←0. `out`, match_cnt and cnt_sat all read 0 after the edge.
- pat_load=1: pattern←pat_in, state←IDLE, match_cnt←0. The `in` bit on that edge is ignored even if en=1.
- en=0: state, pattern and counter hold; `out` holds its value.
- Pattern change is only possible via pat_load. The pattern register is never modified by detection.

## Timing

- Latency: `out` rises in the cycle following the clock edge that sampled the final pattern bit. `match_cnt` updates on the same edge.
- `out` stays high until the next enabled sample, pat_load or reset. With en=0 it may stay high indefinitely.
- No combinational path from any input to any output.
- Reset mid-pattern: the partial prefix is lost and the next match requires a full PAT_W fresh bits.
- pat_load asserted together with a would-be matching sample: the load wins and no count is recorded.

## Configuration

- SEQDET_CNT_EN defined: match counter and saturation logic are built as described.
- SEQDET_CNT_EN undefined: no counter flops; match_cnt tied to 0 and cnt_sat tied to 0. Detection and `out` are unchanged.

## Test plan

- Defaults, reset_n low 2 cycles then stream 1,0,1,1,0,1,0 with en=1 -> out=1 after the 3rd and 6th samples only; match_cnt=2 at the end.
- Defaults, stream 1,0,1,0,1 -> OVERLAP=1 gives out high after samples 3 and 5, match_cnt=2. Same stream with OVERLAP=0 -> out high after sample 3 only, match_cnt=1.
- Stream 1,0 then en=0 for 5 cycles with `in` toggling, then en=1 and in=1 -> out=1 exactly one cycle after that sample; the gated bits are ignored.
- PAT_W=4, pat_load with pat_in=4'b1101 mid-stream, then 1,1,1,0,1 -> match_cnt reset to 0; out high only after the last sample (KMP keeps prefix "11"); match_cnt=1.
- After 1,0 (k=2), reset_n low one edge, then 1 -> out stays 0; the pattern equals PATTERN again and match_cnt=0.
- CNT_W=2 with SEQDET_CNT_EN defined, 5 matches -> match_cnt stops at 3 with cnt_sat=1. Without the macro -> match_cnt=0 and cnt_sat=0 while out still pulses 5 times.
